// File: rtl/assoc_data_cache_pkg.sv
// Shared definitions for the fully-associative write-through data cache.
package assoc_data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_e;

  function automatic int tag_width(input int addr_w, input int offset_w);
    return addr_w - offset_w;
  endfunction

endpackage

// File: rtl/assoc_data_cache_if.sv
// Datapath-side access signals plus the handshaked backing-memory bus.
interface assoc_data_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // cache side
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  // datapath + memory side
  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_victim_select.sv
// Replacement choice: lowest invalid line, else the round-robin pointer.
module assoc_victim_select #(
  parameter  int LINES = 16,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic [LINES-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] victim,
  output logic             used_ptr
);
  always_comb begin
    victim   = rr_ptr;
    used_ptr = 1'b1;
    // descending scan so the lowest invalid index wins
    for (int i = LINES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim   = IDX_W'(i);
        used_ptr = 1'b0;
      end
    end
  end
endmodule

// File: rtl/assoc_data_cache.sv
// Fully-associative write-through, write-no-allocate data cache with
// zero-latency read hits, fill-on-miss and hit/miss counters.
module assoc_data_cache
  import assoc_data_cache_pkg::*;
#(
  parameter int LINES    = 16,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  assoc_data_cache_if.slave bus,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_width(ADDR_W, OFFSET_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  cache_state_e      state, state_nxt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];
  logic [IDX_W-1:0]  rr_ptr, victim, hit_idx;
  logic              used_ptr, hit;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, rdata_q;
  logic [TAG_W-1:0]  cpu_tag;
  logic              wr_issue, rd_hit, rd_miss, fill_done;

  assign cpu_tag = bus.cpu_addr[ADDR_W-1:OFFSET_W];

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid[i] && tag_arr[i] == cpu_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assoc_victim_select #(.LINES(LINES)) u_victim (
    .valid    (valid),
    .rr_ptr   (rr_ptr),
    .victim   (victim),
    .used_ptr (used_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    wr_issue      = 1'b0;
    rd_hit        = 1'b0;
    rd_miss       = 1'b0;
    fill_done     = 1'b0;
    bus.cpu_rdata = rdata_q;
    bus.cpu_stall = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_write) begin
          wr_issue      = 1'b1;
          bus.cpu_stall = 1'b1;
          state_nxt     = WRITE;
        end else if (bus.cpu_read) begin
          if (hit) begin
            rd_hit        = 1'b1;
            bus.cpu_rdata = data_arr[hit_idx];
          end else begin
            rd_miss       = 1'b1;
            bus.cpu_stall = 1'b1;
            state_nxt     = FILL;
          end
        end
      end
      FILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = lat_addr;
        if (bus.mem_ack) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      rr_ptr     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      rdata_q    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      if (wr_issue || rd_miss) lat_addr <= bus.cpu_addr & WORD_MASK;
      if (wr_issue) lat_wdata <= bus.cpu_wdata;
      if (rd_hit || (wr_issue && hit))   hit_count  <= hit_count + CNT_W'(1);
      if (rd_miss || (wr_issue && !hit)) miss_count <= miss_count + CNT_W'(1);
      if (rd_hit) rdata_q <= data_arr[hit_idx];
      // victim is stable across FILL since valid only changes here
      if (fill_done) begin
        valid[victim] <= 1'b1;
        rdata_q       <= bus.mem_rdata;
        if (used_ptr) rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  // tag/data arrays carry no reset; reset only blocks their update
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_issue && hit) data_arr[hit_idx] <= bus.cpu_wdata;
      if (fill_done) begin
        tag_arr[victim]  <= lat_addr[ADDR_W-1:OFFSET_W];
        data_arr[victim] <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_assoc_data_cache.sv
// Scoreboarded random/directed bench for assoc_data_cache with a behavioural cache+memory model.
module tb_assoc_data_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assoc_data_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assoc_data_cache #(.LINES(16), .ADDR_W(32), .DATA_W(32), .OFFSET_W(2), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct { logic [31:0] data; logic [31:0] hits; logic [31:0] misses; } rd_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;

  rd_exp_t     rd_q[$];
  mem_exp_t    mem_q[$];
  int          tests = 0, fails = 0;
  logic [31:0] mem_model [int unsigned];
  bit          line_v [16];
  int unsigned line_w [16];
  int          rr;
  logic [31:0] m_hits, m_misses;
  bit          ack_en = 1'b1;
  bit          pulse_ack = 1'b0;
  int          ack_dly = -1;
  int          last_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned w);
    if (mem_model.exists(w)) return mem_model[w];
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int m_find(input int unsigned w);
    for (int i = 0; i < 16; i++) if (line_v[i] && line_w[i] == w) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    foreach (line_v[i]) line_v[i] = 1'b0;
    rr = 0; m_hits = 0; m_misses = 0;
  endfunction

  function automatic void m_fill(input int unsigned w);
    int v;
    v = -1;
    for (int i = 15; i >= 0; i--) if (!line_v[i]) v = i;
    if (v < 0) begin v = rr; rr = (rr + 1) % 16; end
    line_v[v] = 1'b1; line_w[v] = w;
  endfunction

  // memory responder: checks each request against the expected bus op, then acks
  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_en && !reset && bus.mem_req) begin
        mem_exp_t e; int d; bit ext;
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_unexpected: req we=%0b addr=%h with nothing expected", bus.mem_we, bus.mem_addr);
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", 32'(bus.mem_we), 32'(e.we));
          chk("mem_addr", bus.mem_addr, e.addr);
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
        d   = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        ext = (ack_dly < 0) && ($urandom_range(0, 3) == 0);
        repeat (d) @(posedge clk);
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_we ? $urandom : mem_rd(bus.mem_addr >> 2);
        @(posedge clk); #1;
        if (ext) begin bus.mem_rdata = $urandom; @(posedge clk); #1; end
        bus.mem_ack = 1'b0;
      end else if (pulse_ack) begin
        pulse_ack = 1'b0;
        @(posedge clk); #1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
      end
    end
  end

  // read monitor: a read completes in any non-stalled cycle with cpu_read alone
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.cpu_read && !bus.cpu_write && !bus.cpu_stall) begin
        rd_exp_t e;
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: read completed addr=%h data=%h", bus.cpu_addr, bus.cpu_rdata);
        end else begin
          e = rd_q.pop_front();
          chk("rd_data", bus.cpu_rdata, e.data);
          chk("rd_hit_count", hit_count, e.hits);
          chk("rd_miss_count", miss_count, e.misses);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset(); rd_q.delete(); mem_q.delete();
  endtask

  // issue one access (called just after a rising edge), predict via the model
  task automatic do_op(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned w; int idx; int cyc; int stalls; bit done; bit first;
    rd_exp_t r; mem_exp_t m;
    w = addr >> 2; idx = m_find(w); cyc = 0; stalls = 0; done = 1'b0; first = 1'b1;
    if (wr) begin
      if (idx >= 0) m_hits++; else m_misses++;
      mem_model[w] = wdata;
      m.we = 1'b1; m.addr = addr & 32'hFFFF_FFFC; m.wdata = wdata; mem_q.push_back(m);
    end else if (rd) begin
      if (idx < 0) begin
        m_misses++; m_fill(w);
        m.we = 1'b0; m.addr = addr & 32'hFFFF_FFFC; m.wdata = '0; mem_q.push_back(m);
      end
      r.data = mem_rd(w); r.hits = m_hits; r.misses = m_misses; rd_q.push_back(r);
      m_hits++;
    end
    bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_read = rd; bus.cpu_write = wr;
    while (!done) begin
      @(negedge clk);
      if (wr && first) chk("wr_stall", 32'(bus.cpu_stall), 32'd1);
      first = 1'b0;
      if (wr) done = bus.mem_req && bus.mem_we && bus.mem_ack;
      else if (bus.cpu_stall) stalls++;
      else done = 1'b1;
      cyc++;
      if (!done && cyc > 60) begin
        tests++; fails++;
        $display("FAIL op_timeout: addr=%h wr=%0b rd=%0b", addr, wr, rd);
        done = 1'b1;
      end
    end
    if (rd && !wr) chk("read_miss", 32'(stalls > 0), 32'(idx < 0));
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    last_stalls = stalls;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    reset = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clk); #1;

    // first read miss, ack on the third FILL cycle
    mem_model[32'h40 >> 2] = 32'hDEAD_BEEF; ack_dly = 1;
    do_op(1'b0, 1'b1, 32'h40, '0);
    chk("t1_stall_cycles", last_stalls, 32'd4);
    chk("t1_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_misses", miss_count, 32'd1);
    chk("t1_hits", hit_count, 32'd1);

    // two hits on the same word, different byte offsets
    do_op(1'b0, 1'b1, 32'h40, '0);
    chk("t2_stall_a", last_stalls, 32'd0);
    do_op(1'b0, 1'b1, 32'h43, '0);
    chk("t2_stall_b", last_stalls, 32'd0);
    chk("t2_hits", hit_count, 32'd3);

    // write hit then read back
    ack_dly = 0;
    do_op(1'b1, 1'b0, 32'h40, 32'hA5A5_A5A5);
    do_op(1'b0, 1'b1, 32'h40, '0);
    chk("t3_rdata", bus.cpu_rdata, 32'hA5A5_A5A5);
    chk("t3_hits", hit_count, 32'd5);

    // write miss does not allocate
    do_op(1'b1, 1'b0, 32'h80, 32'h0000_1234);
    chk("t4_wr_misses", miss_count, 32'd2);
    do_op(1'b0, 1'b1, 32'h80, '0);
    chk("t4_rd_misses", miss_count, 32'd3);
    chk("t4_rdata", bus.cpu_rdata, 32'h0000_1234);

    // fill all lines, then round-robin eviction of lines 0 and 1
    do_reset(); ack_dly = -1;
    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 32'(i * 4), '0);
    do_op(1'b0, 1'b1, 32'h1000, '0);
    do_op(1'b0, 1'b1, 32'h2000, '0);
    do_op(1'b0, 1'b1, 32'h008, '0);
    chk("t5_line2_hit", last_stalls, 32'd0);
    do_op(1'b0, 1'b1, 32'h000, '0);
    chk("t5_evicted_miss", 32'(last_stalls > 0), 32'd1);

    // reset during FILL abandons the access; a late ack is ignored
    ack_en = 1'b0;
    bus.cpu_addr = 32'h100; bus.cpu_read = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_fill_req", 32'(bus.mem_req), 32'd1);
    chk("t6_fill_addr", bus.mem_addr, 32'h100);
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset(); rd_q.delete(); mem_q.delete();
    @(negedge clk);
    chk("t6_req_after_rst", 32'(bus.mem_req), 32'd0);
    chk("t6_stall_after_rst", 32'(bus.cpu_stall), 32'd0);
    chk("t6_hits_after_rst", hit_count, 32'd0);
    chk("t6_misses_after_rst", miss_count, 32'd0);
    pulse_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_req_after_ack", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    ack_en = 1'b1;
    do_op(1'b0, 1'b1, 32'h100, '0);
    chk("t6_remiss", 32'(last_stalls > 0), 32'd1);
    chk("t6_misses", miss_count, 32'd1);

    // random traffic over a pool larger than the cache
    for (int n = 0; n < 250; n++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = 32'h200 + 32'($urandom_range(0, 23) * 4) + 32'($urandom_range(0, 3));
      if (op < 6)      do_op(1'b0, 1'b1, a, '0);
      else if (op < 9) do_op(1'b1, 1'b0, a, $urandom);
      else             do_op(1'b1, 1'b1, a, $urandom);
    end

    repeat (5) @(posedge clk);
    chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("end_mem_q_empty", 32'(mem_q.size()), 32'd0);
    chk("end_hits", hit_count, m_hits);
    chk("end_misses", miss_count, m_misses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/assoc_data_cache.md
Name: assoc_data_cache

Overview:
Parametrised fully-associative, write-through data cache between the datapath's ALU_Result/Read_data2/MemWrite/MemRead signals and a handshaked backing data memory.
- Adds valid bits, miss handling with fill from memory, victim replacement, a stall output and hit/miss counters.
- Single clock; all cache state is registered.

Parameters:
LINES, 16, number of cache lines; power of two, at least 2
ADDR_W, 32, byte address width
DATA_W, 32, data word width
OFFSET_W, 2, byte-offset bits dropped from the address; tag = addr[ADDR_W-1:OFFSET_W]
CNT_W, 32, width of the hit and miss counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  access address (ALU_Result)
cpu_wdata  in  DATA_W  store data (Read_data2)
cpu_read  in  1  load request (MemRead)
cpu_write  in  1  store request (MemWrite); has priority over cpu_read
cpu_rdata  out  DATA_W  load data
cpu_stall  out  1  datapath must hold the current access
mem_req  out  1  backing-memory request, held until acknowledged
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word-aligned memory address (offset bits zero)
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  one-cycle completion strobe; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data
hit_count  out  CNT_W  number of hits since reset
miss_count  out  CNT_W  number of misses since reset

Behaviour:
- Reset:
  - all valid bits 0, state IDLE, round-robin pointer 0, counters 0.
  - cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr and mem_wdata are all 0.
  - Tag and data arrays are not cleared.
- Lookup is combinational in IDLE: hit = some valid line has a tag equal to cpu_addr[ADDR_W-1:OFFSET_W]. At most one line can match, because lines are only filled on a miss.
- FSM states: IDLE, FILL, WRITE.
- IDLE, no request: stall 0, mem_req 0, cpu_rdata holds its last value.
- IDLE, read hit:
  - cpu_rdata = matching line data in the same cycle; stall 0; zero-latency.
  - hit_count increments at the clock edge.
- IDLE, read miss:
  - stall 1 combinationally.
  - At the edge, latch the tag, select the victim, increment miss_count and go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {latched tag, OFFSET_W zeros}; stall 1.
  - On mem_ack: write tag, data and valid into the victim line, and register cpu_rdata = mem_rdata.
  - If the victim was the round-robin pointer, advance the pointer mod LINES.
  - Go to IDLE. The following cycle re-looks up and hits, so total read-miss latency is (ack cycle + 1) and that re-lookup also counts as a hit.
- Victim selection: the lowest-indexed invalid line; if all lines are valid, the line at the round-robin pointer. The pointer advances only when it supplied the victim.
- IDLE, write (hit or miss):
  - stall 1.
  - Hit: the matching line's data is updated at this edge.
  - Miss: no allocate (write-no-allocate); miss_count increments; a hit increments hit_count.
  - At the edge, latch address and data, then go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata from the latched values; stall 1.
  - On mem_ack: go to IDLE.
  - Stall therefore falls the cycle after ack, and the datapath then advances. The cache does not re-issue because the bus has moved on: the FSM enters WRITE only from IDLE, and the first IDLE cycle after WRITE is treated as a new access only if the datapath presents one.
- cpu_read and cpu_write both high: treated as a write.
- mem_ack while in IDLE: ignored.
- mem_ack asserted for multiple cycles: only the first ack in FILL or WRITE is acted on.
- Reset in FILL or WRITE: the access is abandoned; mem_req is 0 the next cycle and no line is written.
- Counters wrap modulo 2^CNT_W.
- cpu_addr and cpu_wdata must be held stable by the datapath while stall=1.

Decomposition:
- Shared package: cache FSM state encoding (IDLE=0, FILL=1, WRITE=2) and a tag-width helper constant ADDR_W-OFFSET_W.
- One sub-module, assoc_victim_select: takes the valid vector and the round-robin pointer, returns the victim index and a "used pointer" flag. This is a combinational priority encoder plus mux.

Test Plan:
- Reset, then read addr 0x40 with mem_ack on the 3rd FILL cycle and mem_rdata 0xDEADBEEF:
  - stall is high for 4 cycles and cpu_rdata = 0xDEADBEEF.
  - miss_count=1, then hit_count=1 after the re-lookup.
- Fill 0x40, then read 0x40 and 0x43 (same word):
  - both return data in the same cycle with stall 0; hit_count +2; no mem_req.
- Write 0xA5A5A5A5 to cached 0x40, ack after 2 cycles, then read 0x40:
  - mem_we=1, mem_addr=0x40, mem_wdata=0xA5A5A5A5.
  - The read hits and returns 0xA5A5A5A5.
- Write to uncached 0x80, then read 0x80:
  - miss_count +1 on the write and the read misses (no allocate).
  - The FILL mem_addr is 0x80.
- Fill 16 distinct words, then a 17th (0x1000) and an 18th (0x2000):
  - lines 0 and 1 are evicted in turn.
  - Reading the first word (0x000) afterwards misses.
- Read miss, assert reset mid-FILL, then pulse mem_ack:
  - mem_req=0 after reset and the ack is ignored.
  - A subsequent read of the same address misses again; counters restart at 0.
